// File: rtl/square_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble), one binary bit per clock.
// Valid/ready input handshake, single-cycle completion pulse on out_valid.
module square_bcd_conv #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  busy,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     bin_reg;
  logic [BCD_W-1:0]     bcd_reg;
  logic [CNT_W-1:0]     count;
  logic [BCD_W-1:0]     bcd_adj_c;
  logic [BCD_W+WIDTH-1:0] shifted_c;
  logic                 last_c;
  logic                 accept_c;
  logic                 in_ready_nxt;
  logic                 busy_nxt;
  logic                 out_valid_nxt;

  assign last_c   = (count == CNT_W'(WIDTH - 1));
  assign accept_c = (state == IDLE) && in_valid;

  // Add-3 correction of every digit from current values, then one-bit shift
  always_comb begin
    bcd_adj_c = bcd_reg;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd_reg[4*d +: 4] >= 4'd5) begin
        bcd_adj_c[4*d +: 4] = bcd_reg[4*d +: 4] + 4'd3;
      end
    end
    shifted_c = {bcd_adj_c, bin_reg} << 1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CONV;
      CONV:    if (last_c)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; flags registered so they track the state register
  always_comb begin
    in_ready_nxt  = 1'b0;
    busy_nxt      = 1'b0;
    out_valid_nxt = 1'b0;
    case (state_nxt)
      IDLE:    in_ready_nxt = 1'b1;
      CONV:    busy_nxt     = 1'b1;
      default: in_ready_nxt = 1'b1;
    endcase
    if ((state == CONV) && last_c) begin
      out_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_nxt;
      busy      <= busy_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Datapath: work registers and result holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_reg <= '0;
      bcd_reg <= '0;
      count   <= '0;
      out_bcd <= '0;
    end else if (accept_c) begin
      bin_reg <= in_data;
      bcd_reg <= '0;
      count   <= '0;
    end else if (state == CONV) begin
      bin_reg <= shifted_c[WIDTH-1:0];
      bcd_reg <= shifted_c[BCD_W+WIDTH-1:WIDTH];
      count   <= count + CNT_W'(1);
      if (last_c) begin
        out_bcd <= shifted_c[BCD_W+WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_square_bcd_conv.sv
// Self-checking bench for square_bcd_conv: directed vector table plus
// handshake, back-to-back and mid-conversion reset sequences.
module tb_square_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        busy;
  logic        out_valid;
  logic [11:0] out_bcd;

  int checks;
  int errors;

  typedef struct {
    logic [7:0]  din;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [20];

  square_bcd_conv #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_bcd   (out_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Waits up to 20 cycles for out_valid; k is the cycle it was seen, 0 on timeout
  task automatic wait_out(output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input logic [7:0] d, input logic [11:0] e, input string nm);
    int k;
    @(negedge clk);
    check({nm, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    check({nm, "_busy"}, 32'(busy), 32'd1);
    wait_out(k);
    check({nm, "_lat"}, 32'(k), 32'd8);
    check({nm, "_bcd"}, 32'(out_bcd), 32'(e));
    @(negedge clk);
    check({nm, "_pulse"}, 32'(out_valid), 32'd0);
    check({nm, "_hold"}, 32'(out_bcd), 32'(e));
  endtask

  initial begin
    int k;
    int cnt;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;

    vecs[0]  = '{8'd225, 12'h225};
    vecs[1]  = '{8'd0,   12'h000};
    vecs[2]  = '{8'd255, 12'h255};
    vecs[3]  = '{8'd100, 12'h100};
    vecs[4]  = '{8'd0,   12'h000};
    vecs[5]  = '{8'd1,   12'h001};
    vecs[6]  = '{8'd4,   12'h004};
    vecs[7]  = '{8'd9,   12'h009};
    vecs[8]  = '{8'd16,  12'h016};
    vecs[9]  = '{8'd25,  12'h025};
    vecs[10] = '{8'd36,  12'h036};
    vecs[11] = '{8'd49,  12'h049};
    vecs[12] = '{8'd64,  12'h064};
    vecs[13] = '{8'd81,  12'h081};
    vecs[14] = '{8'd100, 12'h100};
    vecs[15] = '{8'd121, 12'h121};
    vecs[16] = '{8'd144, 12'h144};
    vecs[17] = '{8'd169, 12'h169};
    vecs[18] = '{8'd196, 12'h196};
    vecs[19] = '{8'd225, 12'h225};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(out_bcd), 32'd0);

    for (int i = 0; i < 20; i++) begin
      run_vec(vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Second request while busy is ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd49;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd9;
    check("ign_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(k);
    check("ign_lat", 32'(k), 32'd5);
    check("ign_bcd", 32'(out_bcd), 32'h049);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("ign_extra", 32'(cnt), 32'd0);
    check("ign_hold", 32'(out_bcd), 32'h049);

    // Back-to-back with in_valid held high
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd81;
    @(negedge clk);
    in_data  = 8'd144;
    wait_out(k);
    check("b2b_lat1", 32'(k), 32'd8);
    check("b2b_bcd1", 32'(out_bcd), 32'h081);
    check("b2b_ready1", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd7;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_out(k);
    check("b2b_gap", 32'(k + 1), 32'd9);
    check("b2b_bcd2", 32'(out_bcd), 32'h144);

    // Reset during conversion
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd196;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_bcd", 32'(out_bcd), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("mid_rst_nopulse", 32'(cnt), 32'd0);
    check("mid_rst_hold", 32'(out_bcd), 32'd0);

    run_vec(8'd196, 12'h196, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
